// File: rtl/vga_pkg.sv
// Shared VGA definitions: frame geometry, capture FSM states and
// pixel-format helpers used by the frame-buffer writer and VGA driver.
package vga_pkg;

    localparam int SRC_WIDTH_C  = 640;
    localparam int SRC_HEIGHT_C = 480;
    localparam int DST_WIDTH_C  = 320;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        CAPTURE = 3'b010,
        DONE    = 3'b100
    } fbwState_t;

    // Truncating RGB565 -> RGB444 (drop the LSBs of each channel)
    function automatic logic [11:0] rgb565To444(input logic [15:0] pix);
        return {pix[15:12], pix[10:7], pix[4:1]};
    endfunction

endpackage

// File: rtl/frame_buffer_writer.sv
// Camera stream to 320x240 frame buffer: 2:1 decimation per axis,
// RGB565 -> RGB444, registered write port and frame status pulses.
module frame_buffer_writer
    import vga_pkg::*;
#(
    parameter int SRC_WIDTH  = SRC_WIDTH_C,
    parameter int SRC_HEIGHT = SRC_HEIGHT_C,
    parameter int DST_WIDTH  = DST_WIDTH_C
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset_n,
    input  logic        piul1Valid,
    output logic        poul1Ready,
    input  logic        piul1StartOfFrame,
    input  logic        piul1EndOfLine,
    input  logic [15:0] piul16Pixel,
    output logic        poul1WEnable,
    output logic [16:0] poul17WAddr,
    output logic [11:0] poul12WData,
    output logic        poul1FrameDone,
    output logic        poul1FrameAbort
);

    fbwState_t   state, stateNext;
    logic [9:0]  col, colNext;
    logic [8:0]  row, rowNext;
    logic [16:0] rowBase, rowBaseNext;
    logic        weNext, doneNext, abortNext;
    logic [16:0] addrNext;
    logic [11:0] dataNext;

    logic        accept;
    logic        doBeat;
    logic [9:0]  posCol;
    logic [8:0]  posRow;
    logic [16:0] posBase;

    assign poul1Ready = (state != DONE);
    assign accept     = piul1Valid & poul1Ready;

    // A StartOfFrame beat is always position (0,0), whatever came before
    assign posCol  = piul1StartOfFrame ? '0 : col;
    assign posRow  = piul1StartOfFrame ? '0 : row;
    assign posBase = piul1StartOfFrame ? '0 : rowBase;

    always_comb begin
        stateNext   = state;
        colNext     = col;
        rowNext     = row;
        rowBaseNext = rowBase;
        weNext      = 1'b0;
        addrNext    = poul17WAddr;
        dataNext    = poul12WData;
        doneNext    = 1'b0;
        abortNext   = 1'b0;
        doBeat      = 1'b0;

        unique case (state)
            IDLE: begin
                doBeat = accept & piul1StartOfFrame;
            end
            CAPTURE: begin
                doBeat    = accept;
                abortNext = accept & piul1StartOfFrame;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (doBeat) begin
            stateNext = CAPTURE;
            weNext    = !posCol[0] && !posRow[0]
                        && (posCol < 10'(SRC_WIDTH));
            if (weNext) begin
                addrNext = posBase + 17'(posCol[9:1]);
                dataNext = rgb565To444(piul16Pixel);
            end
            if (piul1EndOfLine) begin
                colNext     = '0;
                rowNext     = posRow + 9'd1;
                // Base tracks the next even row, so bump only after even rows
                rowBaseNext = posRow[0] ? posBase
                                        : posBase + 17'(DST_WIDTH);
                if (posRow == 9'(SRC_HEIGHT - 1)) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end
            end else begin
                colNext     = (posCol < 10'(SRC_WIDTH)) ? posCol + 10'd1
                                                        : posCol;
                rowNext     = posRow;
                rowBaseNext = posBase;
            end
        end
    end

    always_ff @(posedge piul1Clock) begin
        if (!piul1Reset_n) begin
            state           <= IDLE;
            col             <= '0;
            row             <= '0;
            rowBase         <= '0;
            poul1WEnable    <= 1'b0;
            poul17WAddr     <= '0;
            poul12WData     <= '0;
            poul1FrameDone  <= 1'b0;
            poul1FrameAbort <= 1'b0;
        end else begin
            state           <= stateNext;
            col             <= colNext;
            row             <= rowNext;
            rowBase         <= rowBaseNext;
            poul1WEnable    <= weNext;
            poul17WAddr     <= addrNext;
            poul12WData     <= dataNext;
            poul1FrameDone  <= doneNext;
            poul1FrameAbort <= abortNext;
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer on a reduced 8x6 -> 4x3 geometry:
// table vectors, line-length corner cases, mid-frame reset, full frames.
module tb_frame_buffer_writer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 4;
    localparam int DH = H / 2;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        valid = 1'b0;
    logic        sof = 1'b0;
    logic        eol = 1'b0;
    logic [15:0] pix = '0;
    logic        ready, we, done, abort;
    logic [16:0] addr;
    logic [11:0] data;

    frame_buffer_writer #(
        .SRC_WIDTH (W),
        .SRC_HEIGHT(H),
        .DST_WIDTH (DW)
    ) dut (
        .piul1Clock       (clk),
        .piul1Reset_n     (rstN),
        .piul1Valid       (valid),
        .poul1Ready       (ready),
        .piul1StartOfFrame(sof),
        .piul1EndOfLine   (eol),
        .piul16Pixel      (pix),
        .poul1WEnable     (we),
        .poul17WAddr      (addr),
        .poul12WData      (data),
        .poul1FrameDone   (done),
        .poul1FrameAbort  (abort)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] exp444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    function automatic logic [15:0] pixOf(input int x, input int y);
        int v;
        v = (y * W + x) * 32'h0923 + 32'h1357;
        return v[15:0];
    endfunction

    // Drive one cycle from a negedge, check registered outputs at next negedge
    task automatic step(input logic v, input logic s, input logic e,
                        input logic [15:0] p, input logic xWe,
                        input logic [16:0] xAddr, input logic [11:0] xData,
                        input logic xDone, input logic xAbort,
                        input string nm);
        valid = v;
        sof   = s;
        eol   = e;
        pix   = p;
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".we"}, 32'(we), 32'(xWe));
        if (xWe) begin
            chk({nm, ".addr"}, 32'(addr), 32'(xAddr));
            chk({nm, ".data"}, 32'(data), 32'(xData));
        end
        chk({nm, ".done"}, 32'(done), 32'(xDone));
        chk({nm, ".abort"}, 32'(abort), 32'(xAbort));
        chk({nm, ".ready"}, 32'(ready), 32'(!xDone));
        valid = 1'b0;
        sof   = 1'b0;
        eol   = 1'b0;
    endtask

    task automatic doReset();
        rstN  = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    typedef struct {
        logic        v, s, e;
        logic [15:0] p;
        logic        we;
        logic [16:0] addr;
        logic [11:0] data;
        logic        abort;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic s, input logic e,
                                input logic [15:0] p, input logic w,
                                input logic [16:0] a, input logic [11:0] d,
                                input logic ab);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.p = p;
        r.we = w; r.addr = a; r.data = d; r.abort = ab;
        return r;
    endfunction

    // Write monitor for full-frame runs
    bit monOn = 1'b0;
    int expIdx = 0;
    int doneCnt = 0;

    always @(negedge clk) begin
        if (monOn) begin
            if (we) begin
                chk("frameAddr", 32'(addr), 32'(expIdx));
                chk("frameData", 32'(data),
                    32'(exp444(pixOf(2 * (expIdx % DW), 2 * (expIdx / DW)))));
                expIdx++;
            end
            if (done) doneCnt++;
        end
    end

    task automatic fullFrame(input bit gaps, input string nm);
        int stalls;
        int tries;
        logic acc;
        bit timedOut;
        stalls   = 0;
        timedOut = 1'b0;
        expIdx   = 0;
        doneCnt  = 0;
        monOn    = 1'b1;
        for (int y = 0; y < H && !timedOut; y++) begin
            for (int x = 0; x < W && !timedOut; x++) begin
                if (gaps) begin
                    while ($urandom_range(0, 1) == 0) begin
                        valid = 1'b0;
                        @(negedge clk);
                        if (!ready) stalls++;
                    end
                end
                valid = 1'b1;
                sof   = (x == 0 && y == 0);
                eol   = (x == W - 1);
                pix   = pixOf(x, y);
                tries = 0;
                do begin
                    acc = ready;
                    @(posedge clk);
                    @(negedge clk);
                    if (!acc) begin
                        stalls++;
                        tries++;
                    end
                end while (!acc && tries < 8);
                if (!acc) begin
                    chk({nm, ".acceptTimeout"}, 32'(0), 32'(1));
                    timedOut = 1'b1;
                end
            end
        end
        chk({nm, ".doneTiming"}, 32'(done), 32'(1));
        chk({nm, ".readyInDone"}, 32'(ready), 32'(0));
        valid = 1'b0;
        sof   = 1'b0;
        eol   = 1'b0;
        @(negedge clk);
        chk({nm, ".readyAfterDone"}, 32'(ready), 32'(1));
        chk({nm, ".doneCleared"}, 32'(done), 32'(0));
        monOn = 1'b0;
        chk({nm, ".writes"}, 32'(expIdx), 32'(DW * DH));
        chk({nm, ".doneCount"}, 32'(doneCnt), 32'(1));
        chk({nm, ".stalls"}, 32'(stalls), 32'(0));
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk(1, 0, 0, 16'h1234, 0, 0,  12'h000, 0);
        vecs[1]  = mk(1, 1, 0, 16'hF81F, 1, 0,  12'hF0F, 0);
        vecs[2]  = mk(1, 0, 0, 16'h0000, 0, 0,  12'h000, 0);
        vecs[3]  = mk(0, 0, 0, 16'hFFFF, 0, 0,  12'h000, 0);
        vecs[4]  = mk(1, 0, 0, 16'h7BEF, 1, 1,  12'h777, 0);
        vecs[5]  = mk(1, 0, 1, 16'hFFFF, 0, 0,  12'h000, 0);
        vecs[6]  = mk(1, 0, 0, 16'hFFFF, 0, 0,  12'h000, 0);
        vecs[7]  = mk(1, 0, 1, 16'hFFFF, 0, 0,  12'h000, 0);
        vecs[8]  = mk(1, 0, 0, 16'h1234, 1, 4,  12'h14A, 0);
        vecs[9]  = mk(1, 0, 0, 16'hFFFF, 0, 0,  12'h000, 0);
        vecs[10] = mk(1, 0, 0, 16'hFFFF, 1, 5,  12'hFFF, 0);
        vecs[11] = mk(1, 1, 0, 16'h0000, 1, 0,  12'h000, 1);
        vecs[12] = mk(1, 1, 1, 16'hFFFF, 1, 0,  12'hFFF, 1);
        vecs[13] = mk(1, 0, 0, 16'hFFFF, 0, 0,  12'h000, 0);

        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.we", 32'(we), 32'(0));
        chk("rst.addr", 32'(addr), 32'(0));
        chk("rst.data", 32'(data), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.abort", 32'(abort), 32'(0));
        chk("rst.ready", 32'(ready), 32'(1));
        rstN = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].p, vecs[i].we,
                 vecs[i].addr, vecs[i].data, 1'b0, vecs[i].abort,
                 $sformatf("vec%0d", i));
        end

        // Short line 0, then a long line 2, then run to end of frame
        step(1, 1, 0, 16'h0010, 1, 0, 12'h008, 0, 1, "short.sof");
        step(1, 0, 0, 16'h0000, 0, 0, 12'h000, 0, 0, "short.c1");
        step(1, 0, 1, 16'hFFFF, 1, 1, 12'hFFF, 0, 0, "short.eol");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "row1.eol");
        step(1, 0, 0, 16'hF000, 1, 4, 12'hF00, 0, 0, "row2.c0");
        for (int c = 1; c < 12; c++) begin
            step(1, 0, 0, 16'(c * 16'h1111), (c % 2 == 0) && (c < W),
                 17'(4 + c / 2), exp444(16'(c * 16'h1111)), 0, 0,
                 $sformatf("long.c%0d", c));
        end
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "long.eol");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "row3.eol");
        step(1, 0, 0, 16'h0F0F, 1, 8, exp444(16'h0F0F), 0, 0, "row4.c0");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "row4.eol");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 1, 0, "row5.done");
        step(0, 0, 0, 16'h0000, 0, 0, 12'h000, 0, 0, "afterDone");

        // Reset in the middle of a frame
        step(1, 1, 0, 16'hAAAA, 1, 0, exp444(16'hAAAA), 0, 0, "mid.sof");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "mid.eol0");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "mid.eol1");
        rstN = 1'b0;
        step(1, 0, 0, 16'hFFFF, 0, 0, 12'h000, 0, 0, "mid.rst");
        chk("mid.rstAddr", 32'(addr), 32'(0));
        rstN = 1'b1;
        step(1, 0, 0, 16'hFFFF, 0, 0, 12'h000, 0, 0, "mid.ignore");
        step(1, 0, 1, 16'hFFFF, 0, 0, 12'h000, 0, 0, "mid.ignoreEol");
        step(1, 1, 0, 16'h5555, 1, 0, exp444(16'h5555), 0, 0, "mid.resof");

        doReset();
        fullFrame(1'b0, "frame");
        doReset();
        fullFrame(1'b1, "gapFrame");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
